// File: rtl/dec_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dec_chain_pkg
//  Description : Shared widths, output limits and the saturation helper for
//                the decimation-chain output stage.
//  Revision    : 1.0  initial release
// ============================================================================
package dec_chain_pkg;

  localparam int IN_WIDTH_DEF  = 50;
  localparam int OUT_WIDTH_DEF = 24;

  // Saturation is evaluated in a fixed wide signed container so the helper
  // serves any IN_WIDTH up to 63 and any OUT_WIDTH up to 63.
  localparam int SAT_CALC_W = 64;

  localparam logic signed [OUT_WIDTH_DEF-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH_DEF-1){1'b1}}};
  localparam logic signed [OUT_WIDTH_DEF-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH_DEF-1){1'b0}}};

  // Clamp a signed value to the range of an out_w-bit two's complement word.
  // The result is returned sign-extended to SAT_CALC_W bits; a caller detects
  // saturation by comparing the result against the input.
  function automatic logic signed [SAT_CALC_W-1:0] saturate(
    input logic signed [SAT_CALC_W-1:0] value,
    input int                           out_w
  );
    logic signed [SAT_CALC_W-1:0] max_v;
    logic signed [SAT_CALC_W-1:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dec_sync_fifo
//  Description : Single-clock show-ahead FIFO. Pointers carry one extra wrap
//                bit so full and empty are distinguished by the MSB.
//                A push while full is accepted only when a pop happens on the
//                same edge; otherwise it is reported on drop_o.
//  Ports       : clk, rst_n        clock, async active-low reset
//                push_i/push_data_i write request and data
//                pop_i             read request (ignored when empty)
//                head_o            head entry (zero when empty)
//                level_o           occupancy, 0..DEPTH
//                empty_o           FIFO empty
//                drop_o            push rejected this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module dec_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o,
  output logic                     drop_o
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q;
  logic [ADDR_W:0]   rd_ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic full_w;
  logic do_pop_w;
  logic do_push_w;

  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_w    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    do_pop_w  = pop_i & ~empty_o;
    // A pop on the same edge frees the slot the push needs.
    do_push_w = push_i & (~full_w | do_pop_w);
    drop_o    = push_i & full_w & ~do_pop_w;
    wr_ptr_d  = do_push_w ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop_w  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_o   = wr_ptr_q - rd_ptr_q;
    head_o    = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push_w) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dec_out_requant_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dec_out_requant_fifo
//  Description : Output stage of the decimation chain. Applies a programmable
//                rounding right shift, saturates to OUT_WIDTH bits and buffers
//                results in a show-ahead FIFO with a valid/ready output.
//                The input never stalls; samples arriving on a full FIFO are
//                dropped and counted. Latency in_valid -> out_valid is 3 cycles.
//  Ports       : clk, rst_n          clock, async active-low reset
//                in_valid/in_data    sample strobe and signed sample
//                shift               right-shift amount, sampled with in_valid
//                clear_stats         clears sat_count, drop_count, overflow
//                out_valid/out_ready/out_data  output handshake, FIFO head
//                fifo_level          FIFO occupancy
//                sat_count           saturated samples (saturating counter)
//                drop_count          dropped samples (saturating counter)
//                overflow            sticky drop flag
//  Revision    : 1.0  initial release
// ============================================================================
module dec_out_requant_fifo
  import dec_chain_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH = 6,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic [SHIFT_WIDTH-1:0]        shift,
  input  logic                          clear_stats,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   sat_count,
  output logic [15:0]                   drop_count,
  output logic                          overflow
);

  localparam int RW     = IN_WIDTH + 1;
  localparam int S_MAX  = IN_WIDTH - 1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // ---------------- stage 1: rounding shift ----------------
  logic [SHIFT_WIDTH-1:0] s_w;
  logic signed [RW-1:0]   ext_w;
  logic signed [RW-1:0]   bias_w;
  logic signed [RW-1:0]   sum_w;
  logic signed [RW-1:0]   rnd_w;

  always_comb begin
    if (int'(shift) > S_MAX) begin
      s_w = SHIFT_WIDTH'(S_MAX);
    end else begin
      s_w = shift;
    end
    ext_w = {in_data[IN_WIDTH-1], in_data};
    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    bias_w = (s_w == '0) ? '0 : (RW'(1) <<< (s_w - 1'b1));
    sum_w  = ext_w + bias_w;
    rnd_w  = sum_w >>> s_w;
  end

  // ---------------- stage 2: saturation ----------------
  logic signed [SAT_CALC_W-1:0] r1_ext_w;
  logic signed [SAT_CALC_W-1:0] clamp_w;
  logic                         sat_w;

  logic                         v1_q;
  logic                         v1_d;
  logic signed [RW-1:0]         r1_q;
  logic signed [RW-1:0]         r1_d;
  logic                         v2_q;
  logic                         v2_d;
  logic [OUT_WIDTH-1:0]         d2_q;
  logic [OUT_WIDTH-1:0]         d2_d;
  logic [15:0]                  sat_count_q;
  logic [15:0]                  sat_count_d;
  logic [15:0]                  drop_count_q;
  logic [15:0]                  drop_count_d;
  logic                         overflow_q;
  logic                         overflow_d;

  always_comb begin
    r1_ext_w = SAT_CALC_W'(r1_q);
    clamp_w  = saturate(r1_ext_w, OUT_WIDTH);
    sat_w    = v1_q && (clamp_w != r1_ext_w);
  end

  // ---------------- FIFO ----------------
  logic fifo_empty_w;
  logic fifo_drop_w;

  dec_sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (v2_q),
    .push_data_i (d2_q),
    .pop_i       (out_ready),
    .head_o      (out_data),
    .level_o     (fifo_level),
    .empty_o     (fifo_empty_w),
    .drop_o      (fifo_drop_w)
  );

  // ---------------- next state ----------------
  always_comb begin
    v1_d = in_valid;
    r1_d = rnd_w;
    v2_d = v1_q;
    d2_d = clamp_w[OUT_WIDTH-1:0];

    // Clear takes priority over any coincident increment.
    if (clear_stats) begin
      sat_count_d  = '0;
      drop_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      sat_count_d  = (sat_w && sat_count_q != CNT_MAX) ? sat_count_q + 16'd1 : sat_count_q;
      drop_count_d = (fifo_drop_w && drop_count_q != CNT_MAX) ? drop_count_q + 16'd1
                                                              : drop_count_q;
      overflow_d   = overflow_q | fifo_drop_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      r1_q         <= '0;
      v2_q         <= 1'b0;
      d2_q         <= '0;
      sat_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      r1_q         <= r1_d;
      v2_q         <= v2_d;
      d2_q         <= d2_d;
      sat_count_q  <= sat_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    out_valid  = ~fifo_empty_w;
    sat_count  = sat_count_q;
    drop_count = drop_count_q;
    overflow   = overflow_q;
  end

endmodule
`default_nettype wire
